// File: rtl/pid_mc_incr.sv
// -----------------------------------------------------------------------------
// pid_mc_incr : multi-channel incremental (velocity-form) PID controller
//
// Per channel c, on every accepted sample:
//   e(n) = r - y
//   u(n) = u(n-1) + k0*e(n) + k1*e(n-1) + k2*e(n-2)
// The coefficients k0/k1/k2 are precomputed by software from kp/ki/kd.
// NCH channels share one 3-stage pipeline; one sample may enter per cycle,
// in any channel order, and results leave exactly 3 cycles later.
//
// Optional feature (compile-time macro PID_MC_CLAMP_EN):
//   defined   : u(n) clamped to [-L,+L] per channel, o_sat flags a clamp and
//               the clamped value is what gets stored as u(n-1) (anti-windup).
//   undefined : u(n) wraps to OW bits, o_sat is tied 0, no L register, and
//               config writes with sel=3 are ignored.
//
// Parameters
//   NCH  number of channels (>=1)
//   DW   signed width of i_rt / i_yt
//   KW   signed width of k0/k1/k2
//   OW   signed width of o_ut and of the stored u(n-1)
//   CW   channel index width, max(1,$clog2(NCH)) (derived)
//
// Ports
//   i_clkp      clock, all state on rising edge
//   i_rst       asynchronous active-high reset
//   i_valid     sample strobe
//   i_ch        channel index of the sample
//   i_rt        signed target
//   i_yt        signed measurement
//   i_cfg_we    config write strobe
//   i_cfg_clr   clear e(n-1), e(n-2) and u(n-1) of channel i_cfg_ch
//   i_cfg_ch    config channel
//   i_cfg_sel   0:k0 1:k1 2:k2 3:limit L
//   i_cfg_data  write data (coefficients use [KW-1:0], L uses all OW bits)
//   o_valid     result strobe
//   o_ch        channel of result
//   o_ut        signed control output u(n)
//   o_sat       u(n) was clamped for this result
//
// Handshake: there is no backpressure. A sample is accepted on every rising
// edge where i_valid=1 and i_ch < NCH; its result is presented with o_valid=1
// for exactly one cycle, 3 cycles later. o_ch/o_ut/o_sat hold their last value
// while o_valid=0. Out-of-range channels (sample or config) are dropped
// without any state change.
// -----------------------------------------------------------------------------
module pid_mc_incr #(
   parameter  int NCH = 4,
   parameter  int DW  = 16,
   parameter  int KW  = 16,
   parameter  int OW  = 32,
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 i_clkp,
   input  logic                 i_rst,
   input  logic                 i_valid,
   input  logic [CW-1:0]        i_ch,
   input  logic signed [DW-1:0] i_rt,
   input  logic signed [DW-1:0] i_yt,
   input  logic                 i_cfg_we,
   input  logic                 i_cfg_clr,
   input  logic [CW-1:0]        i_cfg_ch,
   input  logic [1:0]           i_cfg_sel,
   input  logic [OW-1:0]        i_cfg_data,
   output logic                 o_valid,
   output logic [CW-1:0]        o_ch,
   output logic signed [OW-1:0] o_ut,
   output logic                 o_sat
);

   // error width: difference of two DW-bit signed values never overflows DW+1
   localparam int EW = DW + 1;
   // product width: EW x KW signed
   localparam int PW = EW + KW;
   // accumulator width: two guard bits over the widest addend so that
   // u(n-1) plus three products never overflows before clamp/wrap
   localparam int SW = ((PW > OW) ? PW : OW) + 2;

   // ---------------------------------------------------------------------------
   // per-channel state
   // ---------------------------------------------------------------------------
   logic signed [EW-1:0] e1_q [NCH];
   logic signed [EW-1:0] e2_q [NCH];
   logic signed [OW-1:0] u_q  [NCH];
   logic signed [KW-1:0] k0_q [NCH];
   logic signed [KW-1:0] k1_q [NCH];
   logic signed [KW-1:0] k2_q [NCH];
`ifdef PID_MC_CLAMP_EN
   logic [OW-1:0]        lim_q [NCH];
`endif

   // ---------------------------------------------------------------------------
   // pipeline registers
   // ---------------------------------------------------------------------------
   logic                 s1_valid;
   logic [CW-1:0]        s1_ch;
   logic signed [EW-1:0] s1_e;
   logic signed [EW-1:0] s1_e1;
   logic signed [EW-1:0] s1_e2;

   logic                 s2_valid;
   logic [CW-1:0]        s2_ch;
   logic signed [PW-1:0] s2_p0;
   logic signed [PW-1:0] s2_p1;
   logic signed [PW-1:0] s2_p2;

   // ---------------------------------------------------------------------------
   // channel decode: one-hot hit vectors. Out-of-range channel indices match
   // no entry, so they are naturally dropped.
   // ---------------------------------------------------------------------------
   logic [NCH-1:0] in_hit;   // sample entering S1 for channel c
   logic [NCH-1:0] clr_hit;  // history/accumulator clear for channel c
   logic [NCH-1:0] we_hit;   // config write for channel c
   logic [NCH-1:0] s3_hit;   // S3 writing back u(n) for channel c

   always_comb begin
      in_hit  = '0;
      clr_hit = '0;
      we_hit  = '0;
      s3_hit  = '0;
      for (int c = 0; c < NCH; c++) begin
         in_hit[c]  = i_valid   && (i_ch     == CW'(c));
         clr_hit[c] = i_cfg_clr && (i_cfg_ch == CW'(c));
         we_hit[c]  = i_cfg_we  && (i_cfg_ch == CW'(c));
         s3_hit[c]  = s2_valid  && (s2_ch    == CW'(c));
      end
   end

   // ---------------------------------------------------------------------------
   // S1: error and history read
   // ---------------------------------------------------------------------------
   logic signed [EW-1:0] e_new;
   logic signed [EW-1:0] e1_rd;
   logic signed [EW-1:0] e2_rd;

   always_comb begin
      e_new = EW'(i_rt) - EW'(i_yt);
      e1_rd = '0;
      e2_rd = '0;
      for (int c = 0; c < NCH; c++) begin
         if (i_ch == CW'(c)) begin
            e1_rd = e1_q[c];
            e2_rd = e2_q[c];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // S2: coefficient read and products
   // Coefficients are read combinationally from the registers, so a config
   // write in the same cycle is only seen by the following sample.
   // ---------------------------------------------------------------------------
   logic signed [KW-1:0] k0_rd;
   logic signed [KW-1:0] k1_rd;
   logic signed [KW-1:0] k2_rd;
   logic signed [PW-1:0] p0_c;
   logic signed [PW-1:0] p1_c;
   logic signed [PW-1:0] p2_c;

   always_comb begin
      k0_rd = '0;
      k1_rd = '0;
      k2_rd = '0;
      for (int c = 0; c < NCH; c++) begin
         if (s1_ch == CW'(c)) begin
            k0_rd = k0_q[c];
            k1_rd = k1_q[c];
            k2_rd = k2_q[c];
         end
      end
      // both operands sign-extended to the full product width first
      p0_c = PW'(s1_e)  * PW'(k0_rd);
      p1_c = PW'(s1_e1) * PW'(k1_rd);
      p2_c = PW'(s1_e2) * PW'(k2_rd);
   end

   // ---------------------------------------------------------------------------
   // S3: accumulate, clamp or wrap
   // u(n-1) is read here (not in S1) so that back-to-back samples of the same
   // channel see the value written on the previous edge, matching serial
   // evaluation without stalls.
   // ---------------------------------------------------------------------------
   logic signed [OW-1:0] u_rd;
   logic signed [SW-1:0] sum_c;
   logic signed [OW-1:0] ut_c;
   logic                 sat_c;

   always_comb begin
      u_rd = '0;
      for (int c = 0; c < NCH; c++) begin
         if (s2_ch == CW'(c)) begin
            u_rd = u_q[c];
         end
      end
      sum_c = SW'(u_rd) + SW'(s2_p0) + SW'(s2_p1) + SW'(s2_p2);
   end

`ifdef PID_MC_CLAMP_EN
   logic [OW-1:0]        lim_rd;
   logic signed [SW-1:0] lim_s;
   logic signed [SW-1:0] res_c;

   always_comb begin
      lim_rd = '0;
      for (int c = 0; c < NCH; c++) begin
         if (s2_ch == CW'(c)) begin
            lim_rd = lim_q[c];
         end
      end
      // L is an unsigned magnitude: zero-extend before treating as signed
      lim_s = $signed(SW'(lim_rd));
      res_c = sum_c;
      sat_c = 1'b0;
      if (sum_c > lim_s) begin
         res_c = lim_s;
         sat_c = 1'b1;
      end else if (sum_c < -lim_s) begin
         res_c = -lim_s;
         sat_c = 1'b1;
      end
      ut_c = res_c[OW-1:0];
   end
`else
   logic [SW-OW-1:0] sum_unused;

   always_comb begin
      // plain two's-complement wrap to the output width
      ut_c       = sum_c[OW-1:0];
      sat_c      = 1'b0;
      sum_unused = sum_c[SW-1:OW];
   end
`endif

   // ---------------------------------------------------------------------------
   // per-channel state update
   // A clear wins over an S1 history shift or S3 write-back of the same
   // channel in the same cycle; samples already in flight keep what they read.
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clkp or posedge i_rst) begin
      if (i_rst) begin
         for (int c = 0; c < NCH; c++) begin
            e1_q[c] <= '0;
            e2_q[c] <= '0;
            u_q[c]  <= '0;
            k0_q[c] <= '0;
            k1_q[c] <= '0;
            k2_q[c] <= '0;
`ifdef PID_MC_CLAMP_EN
            lim_q[c] <= {1'b0, {(OW-1){1'b1}}};
`endif
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (clr_hit[c]) begin
               e1_q[c] <= '0;
               e2_q[c] <= '0;
            end else if (in_hit[c]) begin
               e2_q[c] <= e1_q[c];
               e1_q[c] <= e_new;
            end

            if (clr_hit[c]) begin
               u_q[c] <= '0;
            end else if (s3_hit[c]) begin
               u_q[c] <= ut_c;
            end

            if (we_hit[c]) begin
               case (i_cfg_sel)
                  2'd0:    k0_q[c] <= i_cfg_data[KW-1:0];
                  2'd1:    k1_q[c] <= i_cfg_data[KW-1:0];
                  2'd2:    k2_q[c] <= i_cfg_data[KW-1:0];
`ifdef PID_MC_CLAMP_EN
                  default: lim_q[c] <= i_cfg_data;
`else
                  default: ; // no limit register in the wrapping build
`endif
               endcase
            end
         end
      end
   end

`ifndef PID_MC_CLAMP_EN
   // upper config bits only feed the limit register, absent in this build
   generate
      if (OW > KW) begin : g_cfg_unused
         logic cfg_unused;
         assign cfg_unused = ^i_cfg_data[OW-1:KW];
      end
   endgenerate
`endif

   // ---------------------------------------------------------------------------
   // pipeline and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clkp or posedge i_rst) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1_ch    <= '0;
         s1_e     <= '0;
         s1_e1    <= '0;
         s1_e2    <= '0;
         s2_valid <= 1'b0;
         s2_ch    <= '0;
         s2_p0    <= '0;
         s2_p1    <= '0;
         s2_p2    <= '0;
         o_valid  <= 1'b0;
         o_ch     <= '0;
         o_ut     <= '0;
      end else begin
         // S1 -> S2
         s1_valid <= |in_hit;
         s1_ch    <= i_ch;
         s1_e     <= e_new;
         s1_e1    <= e1_rd;
         s1_e2    <= e2_rd;
         // S2 -> S3
         s2_valid <= s1_valid;
         s2_ch    <= s1_ch;
         s2_p0    <= p0_c;
         s2_p1    <= p1_c;
         s2_p2    <= p2_c;
         // S3 -> outputs; payload held while no result is produced
         o_valid  <= s2_valid;
         if (s2_valid) begin
            o_ch <= s2_ch;
            o_ut <= ut_c;
         end
      end
   end

`ifdef PID_MC_CLAMP_EN
   always_ff @(posedge i_clkp or posedge i_rst) begin
      if (i_rst) begin
         o_sat <= 1'b0;
      end else if (s2_valid) begin
         o_sat <= sat_c;
      end
   end
`else
   assign o_sat = 1'b0;
   logic sat_unused;
   assign sat_unused = sat_c;
`endif

endmodule

// File: tb/tb_pid_mc_incr.sv
// -----------------------------------------------------------------------------
// tb_pid_mc_incr : self-checking bench for pid_mc_incr
// Directed scenarios (steady error, accumulation, clamp, channel interleave,
// clear, reset flush) followed by randomized bursts. Expected results come
// from a serial per-channel model of the control law; a monitor process pops
// and compares them as results appear.
// -----------------------------------------------------------------------------
module tb_pid_mc_incr;

   localparam int NCH = 4;
   localparam int DW  = 16;
   localparam int KW  = 16;
   localparam int OW  = 32;
   localparam int CW  = 2;
   localparam int W   = CW + 1 + OW;

   // ---------------------------------------------------------------------------
   // clock / reset
   // ---------------------------------------------------------------------------
   logic                 i_clkp = 1'b0;
   logic                 i_rst;
   logic                 i_valid;
   logic [CW-1:0]        i_ch;
   logic signed [DW-1:0] i_rt;
   logic signed [DW-1:0] i_yt;
   logic                 i_cfg_we;
   logic                 i_cfg_clr;
   logic [CW-1:0]        i_cfg_ch;
   logic [1:0]           i_cfg_sel;
   logic [OW-1:0]        i_cfg_data;
   logic                 o_valid;
   logic [CW-1:0]        o_ch;
   logic signed [OW-1:0] o_ut;
   logic                 o_sat;

   always #5 i_clkp = ~i_clkp;

   int cyc = 0;
   always @(posedge i_clkp) cyc <= cyc + 1;

   pid_mc_incr #(.NCH(NCH), .DW(DW), .KW(KW), .OW(OW)) dut (
      .i_clkp     (i_clkp),
      .i_rst      (i_rst),
      .i_valid    (i_valid),
      .i_ch       (i_ch),
      .i_rt       (i_rt),
      .i_yt       (i_yt),
      .i_cfg_we   (i_cfg_we),
      .i_cfg_clr  (i_cfg_clr),
      .i_cfg_ch   (i_cfg_ch),
      .i_cfg_sel  (i_cfg_sel),
      .i_cfg_data (i_cfg_data),
      .o_valid    (o_valid),
      .o_ch       (o_ch),
      .o_ut       (o_ut),
      .o_sat      (o_sat)
   );

   // ---------------------------------------------------------------------------
   // scoreboard state and reference model
   // ---------------------------------------------------------------------------
   logic [W-1:0] exp_q[$];
   int           iss_q[$];
   int           checks   = 0;
   int           failures = 0;

   longint m_k0 [NCH];
   longint m_k1 [NCH];
   longint m_k2 [NCH];
   longint m_l  [NCH];
   longint m_e1 [NCH];
   longint m_e2 [NCH];
   longint m_u  [NCH];

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_k0[c] = 0;
         m_k1[c] = 0;
         m_k2[c] = 0;
         m_l[c]  = (longint'(1) <<< (OW - 1)) - 1;
         m_e1[c] = 0;
         m_e2[c] = 0;
         m_u[c]  = 0;
      end
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // driver tasks (inputs change 1 time unit after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_clkp);
         #1;
      end
   endtask

   // One sample; with_clr also clears the same channel in the same cycle:
   // the sample keeps the history it read, but its accumulator read sees 0.
   task automatic issue(input int ch, input int rt, input int yt, input bit with_clr);
      longint               e;
      longint               s;
      logic signed [OW-1:0] ut;
      logic                 sat;
      i_valid = 1'b1;
      i_ch    = CW'(ch);
      i_rt    = DW'(rt);
      i_yt    = DW'(yt);
      if (with_clr) begin
         i_cfg_clr = 1'b1;
         i_cfg_ch  = CW'(ch);
      end
      e   = longint'(i_rt) - longint'(i_yt);
      s   = (with_clr ? 64'sd0 : m_u[ch]) + m_k0[ch] * e + m_k1[ch] * m_e1[ch]
            + m_k2[ch] * m_e2[ch];
      sat = 1'b0;
`ifdef PID_MC_CLAMP_EN
      if (s > m_l[ch]) begin
         s   = m_l[ch];
         sat = 1'b1;
      end else if (s < -m_l[ch]) begin
         s   = -m_l[ch];
         sat = 1'b1;
      end
`endif
      ut      = s[OW-1:0];
      m_u[ch] = longint'(ut);
      if (with_clr) begin
         m_e1[ch] = 0;
         m_e2[ch] = 0;
      end else begin
         m_e2[ch] = m_e1[ch];
         m_e1[ch] = e;
      end
      exp_q.push_back({CW'(ch), sat, ut});
      iss_q.push_back(cyc);
      @(posedge i_clkp);
      #1;
      i_valid   = 1'b0;
      i_cfg_clr = 1'b0;
   endtask

   task automatic cfg(input int ch, input int sel, input longint data);
      logic [OW-1:0] d;
      d          = OW'(data);
      i_cfg_we   = 1'b1;
      i_cfg_ch   = CW'(ch);
      i_cfg_sel  = 2'(sel);
      i_cfg_data = d;
      case (sel)
         0: m_k0[ch] = longint'($signed(d[KW-1:0]));
         1: m_k1[ch] = longint'($signed(d[KW-1:0]));
         2: m_k2[ch] = longint'($signed(d[KW-1:0]));
         default: begin
`ifdef PID_MC_CLAMP_EN
            m_l[ch] = longint'(d);
`endif
         end
      endcase
      @(posedge i_clkp);
      #1;
      i_cfg_we = 1'b0;
   endtask

   task automatic set_k(input int ch, input int k0, input int k1, input int k2);
      cfg(ch, 0, k0);
      cfg(ch, 1, k1);
      cfg(ch, 2, k2);
   endtask

   task automatic clear(input int ch);
      i_cfg_clr = 1'b1;
      i_cfg_ch  = CW'(ch);
      m_e1[ch]  = 0;
      m_e2[ch]  = 0;
      m_u[ch]   = 0;
      @(posedge i_clkp);
      #1;
      i_cfg_clr = 1'b0;
   endtask

   // wait for all expected results, bounded
   task automatic drain();
      int b;
      b = 0;
      while (exp_q.size() != 0 && b < 20) begin
         idle(1);
         b++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
         exp_q.delete();
         iss_q.delete();
      end
      idle(1);
   endtask

   // ---------------------------------------------------------------------------
   // monitor: compare every presented result against the queue head
   // ---------------------------------------------------------------------------
   always @(negedge i_clkp) begin
      if (!i_rst && o_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result ch=%0d ut=%0d expected no result", o_ch, o_ut);
         end else begin
            logic [W-1:0] exp;
            int           iss;
            exp = exp_q.pop_front();
            iss = iss_q.pop_front();
            checks++;
            if ({o_ch, o_sat, o_ut} !== exp) begin
               failures++;
               $display("FAIL result ch=%0d ut=%0d sat=%0d expected ch=%0d ut=%0d sat=%0d",
                        o_ch, o_ut, o_sat, exp[W-1 -: CW], $signed(exp[OW-1:0]), exp[OW]);
            end
            check("latency", longint'(cyc - iss), 3);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // stimulus
   // ---------------------------------------------------------------------------
   initial begin
      i_rst      = 1'b1;
      i_valid    = 1'b0;
      i_ch       = '0;
      i_rt       = '0;
      i_yt       = '0;
      i_cfg_we   = 1'b0;
      i_cfg_clr  = 1'b0;
      i_cfg_ch   = '0;
      i_cfg_sel  = '0;
      i_cfg_data = '0;
      model_reset();
      idle(3);
      check("reset_o_valid", o_valid, 0);
      check("reset_o_ut",    o_ut,    0);
      check("reset_o_ch",    o_ch,    0);
      check("reset_o_sat",   o_sat,   0);
      i_rst = 1'b0;
      idle(1);

      // steady error: k0=2 k1=-2 gives a constant -20
      set_k(0, 2, -2, 0);
      repeat (6) issue(0, 1000, 1010, 1'b0);
      drain();

      // pure integral-like accumulation: -10 .. -60
      set_k(0, 1, 0, 0);
      clear(0);
      repeat (6) issue(0, 1000, 1010, 1'b0);
      drain();
      check("accum_last_ut",  o_ut,  -60);
      check("accum_last_sat", o_sat, 0);

`ifdef PID_MC_CLAMP_EN
      // clamp at L=25, then recovery from the clamped value (anti-windup)
      clear(0);
      cfg(0, 3, 25);
      repeat (4) issue(0, 1000, 1010, 1'b0);
      issue(0, 1000, 990, 1'b0);
      drain();
      check("clamp_recover_ut", o_ut, -15);
      cfg(0, 3, 64'h7fff_ffff);
`else
      // limit writes have no effect in the wrapping build
      cfg(0, 3, 5);
`endif

      // interleaved channels, no cross-talk
      clear(0);
      clear(3);
      set_k(3, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         issue(0, 1000, 1010, 1'b0);
         issue(3, 1000, 1010, 1'b0);
      end
      issue(3, 1000, 1010, 1'b0);
      drain();

      // clear mid-stream on ch0; ch3 keeps its state
      issue(0, 1000, 1010, 1'b0);
      drain();
      clear(0);
      issue(0, 1000, 1010, 1'b0);
      issue(3, 1000, 1010, 1'b0);
      drain();
      // clear colliding with a new sample of the same channel
      issue(0, 1000, 1010, 1'b1);
      issue(0, 1000, 1010, 1'b0);
      issue(0, 1000, 1010, 1'b0);
      drain();

      // reset with two samples in flight
      set_k(0, 2, -2, 0);
      issue(0, 1000, 1010, 1'b0);
      issue(0, 1000, 1010, 1'b0);
      i_rst = 1'b1;
      exp_q.delete();
      iss_q.delete();
      model_reset();
      @(negedge i_clkp);
      idle(1);
      i_rst = 1'b0;
      @(negedge i_clkp);
      check("flush_o_valid", o_valid, 0);
      check("flush_o_ut",    o_ut,    0);
      idle(1);
      set_k(0, 2, -2, 0);
      issue(0, 1000, 1010, 1'b0);
      drain();

      // randomized bursts, config changed only while the pipe is idle
      for (int b = 0; b < 6; b++) begin
         for (int j = 0; j < 4; j++) begin
            int     ch;
            int     sel;
            longint d;
            ch  = $urandom_range(0, NCH - 1);
            sel = $urandom_range(0, 3);
            if (sel == 3) d = $urandom_range(1, 32'h7fff_ffff);
            else if ($urandom_range(0, 1) == 1) d = $urandom;
            else d = longint'($urandom_range(0, 8)) - 4;
            cfg(ch, sel, d);
         end
         if ($urandom_range(0, 1) == 1) clear($urandom_range(0, NCH - 1));
         for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) != 0) begin
               int rt;
               int yt;
               if ($urandom_range(0, 1) == 1) begin
                  rt = int'($urandom_range(0, 65535)) - 32768;
                  yt = int'($urandom_range(0, 65535)) - 32768;
               end else begin
                  rt = int'($urandom_range(0, 200)) - 100;
                  yt = int'($urandom_range(0, 200)) - 100;
               end
               issue($urandom_range(0, NCH - 1), rt, yt, 1'b0);
            end else begin
               idle(1);
            end
         end
         drain();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
